uart_reg_ctrl: RTL and testbench

Command/response controller placed between the AXI-Stream UART RX and TX wrappers. It replaces the development-bench loopback.
- Parses host frames from the RX stream.
- Performs single-register writes and reads on an external register bank (modulator/ADC configuration).
- Returns a fixed 4-byte response frame on the TX stream.
- Drops stalled frames on an inter-byte timeout.

---
 rtl/uart_reg_ctrl_pkg.sv | 9 +
 rtl/uart_reg_ctrl_timeout.sv | 18 +
 rtl/uart_reg_ctrl.sv | 87 ++++++++
 tb/tb_uart_reg_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_ctrl_pkg.sv
// uart_reg_ctrl_pkg: shared frame constants and parser states for the UART register controller
package uart_reg_ctrl_pkg;
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam logic [7:0] RESP_BYTE      = 8'h5A;
    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_CHK_ERR = 8'hE1;
    localparam int         CMD_WR_BIT     = 7;
    typedef enum logic [2:0] {IDLE, CMD, DATA, CHK, EXEC, RESP} state_t;
endpackage

// File: rtl/uart_reg_ctrl_timeout.sv
// frame_timeout: inter-byte counter that flags expiry on the cycle it would reach TIMEOUT_CYCLES
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expire = enable && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: parses A5-framed host commands, accesses the register bank and returns a 4-byte response
module uart_reg_ctrl
    import uart_reg_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       i_tready,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rd_data,
    output logic       timeout_err,
    output logic       chk_err
);
    state_t     state, state_nx;
    logic       hs_in, hs_out, in_frame, expire, wr, match;
    logic [7:0] status, data;
    logic [1:0] idx;
    assign i_tready  = (state != EXEC) && (state != RESP);
    assign in_frame  = (state == CMD) || (state == DATA) || (state == CHK);
    assign hs_in     = i_tvalid && i_tready;
    assign hs_out    = o_tvalid && o_tready;
    assign reg_wr_en = !rst && (state == EXEC) && match && wr;
    assign chk_err   = !rst && (state == EXEC) && !match;
    frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (hs_in || !in_frame),
        .enable (in_frame),
        .expire (expire)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (hs_in && i_tdata == SYNC_BYTE) ? CMD : IDLE;
            CMD:     state_nx = hs_in ? (i_tdata[CMD_WR_BIT] ? DATA : CHK) : expire ? IDLE : CMD;
            DATA:    state_nx = hs_in ? CHK : expire ? IDLE : DATA;
            CHK:     state_nx = hs_in ? EXEC : expire ? IDLE : CHK;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = (hs_out && idx == 2'd3) ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // a byte accepted on the expiry cycle wins, so the error only fires without a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_addr    <= '0;
            reg_wr_data <= '0;
            wr          <= 1'b0;
            match       <= 1'b0;
            status      <= '0;
            data        <= '0;
            o_tdata     <= '0;
            o_tvalid    <= 1'b0;
            idx         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= in_frame && expire && !hs_in;
            if (hs_in && state == CMD) {wr, reg_addr} <= i_tdata;
            if (hs_in && state == DATA) reg_wr_data <= i_tdata;
            if (hs_in && state == CHK)
                match <= i_tdata == (wr ? {wr, reg_addr} ^ reg_wr_data : {wr, reg_addr});
            if (state == EXEC) begin
                status   <= match ? STATUS_OK : STATUS_CHK_ERR;
                data     <= !match ? 8'h00 : wr ? reg_wr_data : reg_rd_data;
                o_tdata  <= RESP_BYTE;
                o_tvalid <= 1'b1;
                idx      <= '0;
            end
            if (hs_out) begin
                idx      <= idx + 2'd1;
                o_tdata  <= idx == 2'd0 ? status : idx == 2'd1 ? data : status ^ data;
                o_tvalid <= idx != 2'd3;
            end
        end
    end
endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb_uart_reg_ctrl: directed frames with a scoreboard of expected response bytes
module tb_uart_reg_ctrl;
    import uart_reg_ctrl_pkg::*;
    localparam int TO = 4000;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_tdata;
    logic       i_tvalid;
    logic       i_tready;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tready;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic [7:0] reg_rd_data;
    logic       timeout_err;
    logic       chk_err;
    logic [7:0] bank [128];
    logic [7:0] q [$];
    int         total = 0;
    int         pass = 0;
    int         wr_cnt = 0;
    int         chk_cnt = 0;
    int         to_cnt = 0;
    logic       stable;

    uart_reg_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tdata     (i_tdata),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_data (reg_rd_data),
        .timeout_err (timeout_err),
        .chk_err     (chk_err)
    );

    always #5 clk = ~clk;

    assign reg_rd_data = bank[reg_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) bank[i] <= 8'(i);
            bank[7'h12] <= 8'h77;
        end else if (reg_wr_en) begin
            bank[reg_addr] <= reg_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reg_wr_en) wr_cnt++;
        if (chk_err) chk_cnt++;
        if (timeout_err) to_cnt++;
        if (o_tvalid && o_tready) begin
            check("tx_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) check("tx_byte", o_tdata, q.pop_front());
        end
    end

    task automatic push_resp(input logic [7:0] st, input logic [7:0] d);
        q.push_back(RESP_BYTE);
        q.push_back(st);
        q.push_back(d);
        q.push_back(st ^ d);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_tdata  = b;
        i_tvalid = 1'b1;
        while (!i_tready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) check("rx_ready_timeout", i_tready, 1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] d, input logic [7:0] chk);
        send_byte(SYNC_BYTE);
        send_byte(cmd);
        if (cmd[7]) send_byte(d);
        send_byte(chk);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_done", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_tdata = 8'h00;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wr_data, 0);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_itready", i_tready, 1);
        rst = 1'b0;
        o_tready = 1'b1;
        // write 0x3C to address 0x05
        push_resp(STATUS_OK, 8'h3C);
        send_frame(8'h85, 8'h3C, 8'hB9);
        check("wr_en_exec", reg_wr_en, 1);
        check("wr_addr", reg_addr, 7'h05);
        check("wr_data", reg_wr_data, 8'h3C);
        check("exec_tvalid", o_tvalid, 0);
        check("exec_itready", i_tready, 0);
        @(posedge clk);
        #1;
        check("wr_en_pulse", reg_wr_en, 0);
        check("tvalid_rise", o_tvalid, 1);
        check("resp_itready", i_tready, 0);
        wait_resp();
        check("tvalid_fall", o_tvalid, 0);
        check("idle_itready", i_tready, 1);
        check("wr_cnt_1", wr_cnt, 1);
        // read 0x12 and read back the written 0x05
        push_resp(STATUS_OK, 8'h77);
        send_frame(8'h12, 8'h00, 8'h12);
        check("rd_no_wr_en", reg_wr_en, 0);
        wait_resp();
        push_resp(STATUS_OK, 8'h3C);
        send_frame(8'h05, 8'h00, 8'h05);
        wait_resp();
        check("wr_cnt_reads", wr_cnt, 1);
        // bad checksum
        push_resp(STATUS_CHK_ERR, 8'h00);
        send_frame(8'h85, 8'h3C, 8'h00);
        check("bad_chk_err", chk_err, 1);
        check("bad_no_wr_en", reg_wr_en, 0);
        @(posedge clk);
        #1;
        check("chk_err_pulse", chk_err, 0);
        wait_resp();
        check("chk_cnt", chk_cnt, 1);
        check("wr_cnt_bad", wr_cnt, 1);
        // garbage then a stalled write frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(SYNC_BYTE);
        send_byte(8'h85);
        check("to_addr", reg_addr, 7'h05);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_early", timeout_err, 0);
        @(posedge clk);
        #1;
        check("to_pulse", timeout_err, 1);
        @(posedge clk);
        #1;
        check("to_pulse_end", timeout_err, 0);
        check("to_cnt", to_cnt, 1);
        check("to_no_tx", o_tvalid, 0);
        check("to_wr_cnt", wr_cnt, 1);
        push_resp(STATUS_OK, 8'h77);
        send_frame(8'h12, 8'h00, 8'h12);
        wait_resp();
        // back-pressure on the response
        o_tready = 1'b0;
        push_resp(STATUS_OK, 8'h77);
        send_frame(8'h12, 8'h00, 8'h12);
        @(posedge clk);
        #1;
        check("bp_tvalid", o_tvalid, 1);
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (!(o_tvalid && o_tdata == RESP_BYTE && !i_tready)) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        o_tready = 1'b1;
        wait_resp();
        check("bp_tvalid_fall", o_tvalid, 0);
        // reset after the second response byte
        q.push_back(RESP_BYTE);
        q.push_back(STATUS_OK);
        send_frame(8'h12, 8'h00, 8'h12);
        wait_resp();
        check("mid_tvalid", o_tvalid, 1);
        o_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tvalid", o_tvalid, 0);
        check("rst_mid_itready", i_tready, 1);
        check("rst_mid_wr_en", reg_wr_en, 0);
        rst = 1'b0;
        o_tready = 1'b1;
        @(posedge clk);
        #1;
        check("no_resume", o_tvalid, 0);
        push_resp(STATUS_OK, 8'h77);
        send_frame(8'h12, 8'h00, 8'h12);
        wait_resp();
        check("wr_cnt_final", wr_cnt, 1);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
